true_dual_port_ram: RTL and testbench



---
 rtl/true_dual_port_ram.sv | 79 +++++++
 tb/tb_true_dual_port_ram.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/true_dual_port_ram.sv
// Two-port synchronous RAM on a single clock: registered reads, write-first on
// the writing port, read-first across ports, and port A wins same-address writes.
module true_dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_in_a,
  output logic [DATA_WIDTH-1:0] data_out_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_in_b,
  output logic [DATA_WIDTH-1:0] data_out_b
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  in_range_a;
  logic                  in_range_b;
  logic                  wr_a;
  logic                  wr_b;
  logic [DATA_WIDTH-1:0] data_out_a_d;
  logic [DATA_WIDTH-1:0] data_out_a_q;
  logic [DATA_WIDTH-1:0] data_out_b_d;
  logic [DATA_WIDTH-1:0] data_out_b_q;

  assign in_range_a = (32'(addr_a) < RAM_DEPTH);
  assign in_range_b = (32'(addr_b) < RAM_DEPTH);
  assign wr_a       = en_a & we_a & in_range_a;
  assign wr_b       = en_b & we_b & in_range_b;

  // Reads sample the array before this edge's writes land, giving read-first
  // behaviour across ports; the writing port echoes its own input.
  always_comb begin
    data_out_a_d = data_out_a_q;
    if (en_a) begin
      if (we_a)            data_out_a_d = data_in_a;
      else if (in_range_a) data_out_a_d = mem[addr_a];
      else                 data_out_a_d = '0;
    end
  end

  always_comb begin
    data_out_b_d = data_out_b_q;
    if (en_b) begin
      if (we_b)            data_out_b_d = data_in_b;
      else if (in_range_b) data_out_b_d = mem[addr_b];
      else                 data_out_b_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_a_q <= '0;
      data_out_b_q <= '0;
    end else begin
      data_out_a_q <= data_out_a_d;
      data_out_b_q <= data_out_b_d;
    end
  end

  // Port A's write is issued last so it overrides B on a shared address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_b) mem[addr_b] <= data_in_b;
      if (wr_a) mem[addr_a] <= data_in_a;
    end
  end

  assign data_out_a = data_out_a_q;
  assign data_out_b = data_out_b_q;

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Scoreboard bench for true_dual_port_ram: a behavioural memory model predicts
// each port's read data per cycle; predictions are queued and compared after the edge.
module tb_true_dual_port_ram;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          en_a, we_a, en_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_in_a, data_in_b;
  logic [DW-1:0] data_out_a, data_out_b;

  true_dual_port_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RAM_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_a      (en_a),
    .we_a      (we_a),
    .addr_a    (addr_a),
    .data_in_a (data_in_a),
    .data_out_a(data_out_a),
    .en_b      (en_b),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .data_in_b (data_in_b),
    .data_out_b(data_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] mdo_a, mdo_b;
  logic [DW-1:0] exp_a_q [$];
  logic [DW-1:0] exp_b_q [$];

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  // Drive one cycle on both ports, predict outputs from the model, then compare after the edge.
  task automatic cycle(input string tag,
                       input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic [DW-1:0] pa, pb;
    en_a = ea; we_a = wa; addr_a = aa; data_in_a = da;
    en_b = eb; we_b = wb; addr_b = ab; data_in_b = db;
    pa = mdo_a;
    pb = mdo_b;
    if (ea) pa = wa ? da : mdl[aa];
    if (eb) pb = wb ? db : mdl[ab];
    if (eb && wb) mdl[ab] = db;
    if (ea && wa) mdl[aa] = da;
    mdo_a = pa;
    mdo_b = pb;
    exp_a_q.push_back(pa);
    exp_b_q.push_back(pb);
    @(posedge clk);
    #1;
    check({tag, "_a"}, data_out_a, exp_a_q.pop_front());
    check({tag, "_b"}, data_out_b, exp_b_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    mdo_a = '0; mdo_b = '0;
    rst = 1'b1;
    en_a = 0; we_a = 0; addr_a = '0; data_in_a = '0;
    en_b = 0; we_b = 0; addr_b = '0; data_in_b = '0;
    #2;
    check("reset_a", data_out_a, 8'h00);
    check("reset_b", data_out_b, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Known contents for locations the directed tests read before writing.
    cycle("pre0", 1, 1, 8'h06, 8'h00, 1, 1, 8'h08, 8'h44);
    cycle("pre1", 1, 1, 8'h07, 8'h5A, 0, 0, 8'h00, 8'h00);

    cycle("a_wr", 1, 1, 8'h01, 8'hAA, 0, 0, 8'h00, 8'h00);
    check("a_wr_first", data_out_a, 8'hAA);
    cycle("a_rd", 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00);
    check("a_rd_lit", data_out_a, 8'hAA);

    cycle("b_wr", 0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'hBB);
    cycle("b_rd", 0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00);
    check("b_rd_lit", data_out_b, 8'hBB);
    check("a_hold_lit", data_out_a, 8'hAA);

    cycle("dual_wr", 1, 1, 8'h03, 8'hCC, 1, 1, 8'h04, 8'hDD);
    cycle("dual_rd", 1, 0, 8'h03, 8'h00, 1, 0, 8'h04, 8'h00);
    check("dual_rd_a_lit", data_out_a, 8'hCC);
    check("dual_rd_b_lit", data_out_b, 8'hDD);

    cycle("coll_wr", 1, 1, 8'h05, 8'hEE, 1, 1, 8'h05, 8'hFF);
    check("coll_wr_b_lit", data_out_b, 8'hFF);
    cycle("coll_rd", 1, 0, 8'h05, 8'h00, 1, 0, 8'h05, 8'h00);
    check("coll_rd_a_lit", data_out_a, 8'hEE);
    check("coll_rd_b_lit", data_out_b, 8'hEE);

    cycle("xrw", 1, 1, 8'h06, 8'h11, 1, 0, 8'h06, 8'h00);
    check("xrw_old_lit", data_out_b, 8'h00);
    cycle("xrw_nxt", 1, 0, 8'h06, 8'h00, 1, 0, 8'h06, 8'h00);
    check("xrw_new_lit", data_out_b, 8'h11);

    cycle("dis", 0, 1, 8'h07, 8'h22, 0, 1, 8'h07, 8'h33);
    check("dis_hold_lit", data_out_a, 8'h11);

    // Reset pulse between edges clears outputs at once; memory survives.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_pulse_a", data_out_a, 8'h00);
    check("rst_pulse_b", data_out_b, 8'h00);
    mdo_a = '0; mdo_b = '0;
    #1;
    rst = 1'b0;
    cycle("post_rst", 1, 0, 8'h06, 8'h00, 1, 0, 8'h07, 8'h00);
    check("post_rst_lit", data_out_a, 8'h11);
    check("dis_mem_lit", data_out_b, 8'h5A);

    // An access on an edge with rst high must be ignored.
    @(negedge clk);
    rst = 1'b1;
    en_a = 1; we_a = 1; addr_a = 8'h08; data_in_a = 8'h99;
    en_b = 1; we_b = 0; addr_b = 8'h06; data_in_b = 8'h00;
    @(posedge clk);
    #1;
    check("rst_edge_a", data_out_a, 8'h00);
    check("rst_edge_b", data_out_b, 8'h00);
    mdo_a = '0; mdo_b = '0;
    @(negedge clk);
    rst = 1'b0;
    cycle("rst_nowr", 1, 0, 8'h08, 8'h00, 0, 0, 8'h00, 8'h00);
    check("rst_nowr_lit", data_out_a, 8'h44);

    // Randomised traffic over a small preloaded window to provoke collisions.
    for (int i = 0; i < 16; i++)
      cycle("pre_rand", 1, 1, AW'(8'h10 + i), DW'($urandom), 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 80; i++)
      cycle("rand",
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            AW'(8'h10 + $urandom_range(0, 3)), DW'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            AW'(8'h10 + $urandom_range(0, 3)), DW'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
